// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    // Operation encodings carried on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result selection for the multiply/divide unit.
// raw_hi/raw_lo are the unsigned magnitude results of the iterative core.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             div_by_zero,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             is_signed;
    logic             is_div;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    // Negate product, quotient or remainder according to operand signs
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div    = op[1];
        prod      = {raw_hi, raw_lo};
        prod_neg  = -prod;
        hi        = raw_hi;
        lo        = raw_lo;
        if (!is_div) begin
            if (is_signed && (sign_a ^ sign_b)) begin
                {hi, lo} = prod_neg;
            end
        end else begin
            // With a zero divisor the remainder magnitude equals |src_a|, so
            // re-applying the dividend sign reproduces src_a as sampled.
            if (is_signed && sign_a) begin
                hi = -raw_hi;
            end
            if (div_by_zero) begin
                lo = '1;
            end else if (is_signed && (sign_a ^ sign_b)) begin
                lo = -raw_lo;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring shift-subtract divide.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    logic [1:0]       op_q;
    logic             sign_a;
    logic             sign_b;
    logic             dbz_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc;      // product upper half (+carry) or partial remainder
    logic [WIDTH-1:0] mq;       // multiplier bits, or dividend shifting into quotient
    logic [WIDTH-1:0] mag_b;

    logic             start_signed;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mq_next;

    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // Operand magnitudes and sign flags captured on start
    always_comb begin
        start_signed = (op == OP_MULT) || (op == OP_DIV);
        neg_a        = start_signed && src_a[WIDTH-1];
        neg_b        = start_signed && src_b[WIDTH-1];
        abs_a        = neg_a ? -src_a : src_a;
        abs_b        = neg_b ? -src_b : src_b;
    end

    // One iteration of the multiply or divide recurrence
    always_comb begin
        mul_sum   = acc + {1'b0, mag_b};
        div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, mag_b};
        if (op_q[1]) begin
            if (!div_trial[WIDTH+1]) begin
                acc_next = div_trial[WIDTH:0];
                mq_next  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = div_shift;
                mq_next  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mq[0]) begin
                {acc_next, mq_next} = {mul_sum, mq} >> 1;
            end else begin
                {acc_next, mq_next} = {acc, mq} >> 1;
            end
        end
    end

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op          (op_q),
        .sign_a      (sign_a),
        .sign_b      (sign_b),
        .div_by_zero (dbz_q),
        .raw_hi      (acc[WIDTH-1:0]),
        .raw_lo      (mq),
        .hi          (fix_hi),
        .lo          (fix_lo)
    );

    // Sequencer, iteration datapath and HI/LO architectural registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= OP_MULT;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dbz_q       <= 1'b0;
            count       <= '0;
            acc         <= '0;
            mq          <= '0;
            mag_b       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        sign_a      <= neg_a;
                        sign_b      <= neg_b;
                        mag_b       <= abs_b;
                        dbz_q       <= op[1] && (src_b == '0);
                        acc         <= '0;
                        mq          <= abs_a;
                        count       <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= CALC;
                    end else begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mq    <= mq_next;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= dbz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand sequences,
// results compared through a scoreboard when done pulses.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wr_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        s8_start, s8_hi_we, s8_lo_we;
    logic [1:0]  s8_op;
    logic [7:0]  s8_a, s8_b, s8_wr_data;
    logic        s8_busy, s8_done, s8_dbz;
    logic [7:0]  s8_hi, s8_lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .op(s8_op), .src_a(s8_a), .src_b(s8_b),
        .hi_we(s8_hi_we), .lo_we(s8_lo_we), .wr_data(s8_wr_data), .busy(s8_busy), .done(s8_done),
        .div_by_zero(s8_dbz), .hi(s8_hi), .lo(s8_lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       name;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results: {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == OP_MULT) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end else if (o == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end else if (b == 32'b0) begin
            return {1'b1, a, 32'hFFFFFFFF};
        end else if (o == OP_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            return {1'b0, r, q};
        end else begin
            q = a / b;
            r = a % b;
            return {1'b0, r, q};
        end
    endfunction

    // Scoreboard for the 32-bit unit
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst && done) begin
            if (sb32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done32: got done=1 required no pending op");
            end else begin
                e = sb32.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check({e.name, "_dbz"}, div_by_zero, e.dbz);
            end
        end
    end

    // Scoreboard for the 8-bit unit
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst && s8_done) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 required no pending op");
            end else begin
                e = sb8.pop_front();
                check({e.name, "_hi"}, s8_hi, e.hi);
                check({e.name, "_lo"}, s8_lo, e.lo);
                check({e.name, "_dbz"}, s8_dbz, e.dbz);
            end
        end
    end

    task automatic push32(input string name, input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ed; e.name = name;
        sb32.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, done, 1);
    endtask

    task automatic run32(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int          n, bc;
        logic [31:0] h0, l0;
        bit          moved;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        push32(name, eh, el, ed);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_dbz_clr"}, div_by_zero, 0);
        h0 = hi; l0 = lo; moved = 1'b0;
        n = 0; bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, 33);
        check({name, "_busy_cycles"}, bc, 33);
        check({name, "_hilo_stable"}, moved, 0);
    endtask

    task automatic run8(input string name, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
        int   n;
        exp_t e;
        @(negedge clk);
        s8_start = 1'b1; s8_op = o; s8_a = a; s8_b = b;
        e.hi = {24'b0, eh}; e.lo = {24'b0, el}; e.dbz = 1'b0; e.name = name;
        sb8.push_back(e);
        @(posedge clk); #1;
        s8_start = 1'b0;
        n = 0;
        while (!s8_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, 9);
    endtask

    initial begin
        logic [64:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b0;
        start = 1'b0; op = OP_MULT; src_a = '0; src_b = '0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        s8_start = 1'b0; s8_op = OP_MULT; s8_a = '0; s8_b = '0; s8_hi_we = 1'b0; s8_lo_we = 1'b0; s8_wr_data = '0;

        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0});
        vecs.push_back('{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0});
        vecs.push_back('{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0});

        // Reset state
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst8_hilo", {s8_hi, s8_lo}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
            m  = model(ro, ra, rb);
            run32($sformatf("rnd%0d", i), ro, ra, rb, m[63:32], m[31:0], m[64]);
        end

        // MTHI while busy is dropped
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
        push32("mthi_busy_op", 32'h0, 32'd12, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        ra = hi;
        @(negedge clk);
        hi_we = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_busy_hi", hi, ra);
        wait_done("mthi_busy_op");

        // MTLO in idle
        @(negedge clk);
        lo_we = 1'b1; wr_data = 32'hABCD;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_idle_lo", lo, 32'hABCD);
        check("mtlo_idle_hi", hi, 32'h0);

        // MTHI and MTLO together
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both", {hi, lo}, {32'h5A5A, 32'h5A5A});

        // MTLO on the same edge as start is dropped
        @(negedge clk);
        lo_we = 1'b1; wr_data = 32'h5555;
        start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
        push32("mtlo_start_op", 32'h0, 32'd6, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        check("mtlo_start_dropped", lo, 32'h5A5A);
        wait_done("mtlo_start_op");

        // Reset mid-operation aborts with no done
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hFFFF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = OP_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_hilo", {hi, lo}, 0);

        // Narrow instance
        run8("w8_multu", OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8_div_ovf", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);

        repeat (2) @(negedge clk);
        check("sb32_drained", sb32.size(), 0);
        check("sb8_drained", sb8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
